// File: rtl/mips_decode_exec_unit.sv
// Decode/execute slice of a single-cycle MIPS: 32x32 register file with write-through,
// main control decoder, ALU control and a 32-bit ALU.
module mips_decode_exec_unit (
    input  logic        clock,
    input  logic        reset_n,
    // Main control
    input  logic [5:0]  opcode,
    // Register file
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic [31:0] out_rs,
    output logic [31:0] out_rt,
    input  logic        sinal_escrita,
    input  logic [4:0]  reg_escrita,
    input  logic [31:0] dado_escrita,
    // Control outputs
    output logic [1:0]  c_ALUOp,
    output logic [1:0]  c_memoria,
    output logic [2:0]  c_desvio,
    output logic        c_fonte_ula,
    output logic        c_memtoreg,
    output logic        c_escrever_reg,
    output logic        c_reg_destino,
    // ALU
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [5:0]  alu_funct,
    input  logic [1:0]  alu_op,
    output logic [31:0] resultado,
    output logic        zero,
    output logic        overflow
);

    // ------------------------------------------------------------------
    // Opcodes and function codes
    // ------------------------------------------------------------------
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnNor = 6'b100111;
    localparam logic [5:0] FnSlt = 6'b101010;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluNor,
        AluSlt
    } alu_sel_e;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = sinal_escrita && (reg_escrita != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[reg_escrita] = dado_escrita;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reset forces reads to zero; otherwise a pending write bypasses the array.
    always_comb begin
        out_rs = '0;
        out_rt = '0;
        if (reset_n) begin
            if (rs != 5'd0) begin
                out_rs = (wr_en && (reg_escrita == rs)) ? dado_escrita : regs_q[rs];
            end
            if (rt != 5'd0) begin
                out_rt = (wr_en && (reg_escrita == rt)) ? dado_escrita : regs_q[rt];
            end
        end
    end

    // ------------------------------------------------------------------
    // Main control decoder
    // ------------------------------------------------------------------
    always_comb begin
        c_ALUOp        = 2'b00;
        c_memoria      = 2'b00;
        c_desvio       = 3'b000;
        c_fonte_ula    = 1'b0;
        c_memtoreg     = 1'b0;
        c_escrever_reg = 1'b0;
        c_reg_destino  = 1'b0;
        case (opcode)
            OpRType: begin
                c_ALUOp        = 2'b10;
                c_escrever_reg = 1'b1;
                c_reg_destino  = 1'b1;
            end
            OpLw: begin
                c_memoria      = 2'b01;
                c_fonte_ula    = 1'b1;
                c_memtoreg     = 1'b1;
                c_escrever_reg = 1'b1;
            end
            OpSw: begin
                c_memoria   = 2'b10;
                c_fonte_ula = 1'b1;
            end
            OpBeq: begin
                c_ALUOp  = 2'b01;
                c_desvio = 3'b001;
            end
            OpBne: begin
                c_ALUOp  = 2'b01;
                c_desvio = 3'b010;
            end
            OpAddi: begin
                c_fonte_ula    = 1'b1;
                c_escrever_reg = 1'b1;
            end
            OpJ: begin
                c_desvio = 3'b100;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU control
    // ------------------------------------------------------------------
    alu_sel_e alu_sel;

    always_comb begin
        alu_sel = AluAdd;
        case (alu_op)
            2'b01: alu_sel = AluSub;
            2'b10: begin
                case (alu_funct)
                    FnAdd:   alu_sel = AluAdd;
                    FnSub:   alu_sel = AluSub;
                    FnAnd:   alu_sel = AluAnd;
                    FnOr:    alu_sel = AluOr;
                    FnNor:   alu_sel = AluNor;
                    FnSlt:   alu_sel = AluSlt;
                    default: alu_sel = AluAdd;
                endcase
            end
            default: alu_sel = AluAdd;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic        slt_bit;

    assign sum     = alu_a + alu_b;
    assign diff    = alu_a - alu_b;
    assign add_ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
    assign sub_ovf = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
    // Differing signs decide SLT directly, so a wrapped difference never matters.
    assign slt_bit = (alu_a[31] != alu_b[31]) ? alu_a[31] : diff[31];

    always_comb begin
        resultado = sum;
        overflow  = 1'b0;
        unique case (alu_sel)
            AluAdd: begin
                resultado = sum;
                overflow  = add_ovf;
            end
            AluSub: begin
                resultado = diff;
                overflow  = sub_ovf;
            end
            AluAnd:  resultado = alu_a & alu_b;
            AluOr:   resultado = alu_a | alu_b;
            AluNor:  resultado = ~(alu_a | alu_b);
            AluSlt:  resultado = {31'd0, slt_bit};
            default: resultado = sum;
        endcase
    end

    assign zero = (resultado == 32'd0);

endmodule

// File: tb/tb_mips_decode_exec_unit.sv
// Self-checking bench for mips_decode_exec_unit: directed spec scenarios plus randomized
// register-file and ALU traffic checked against a behavioural model.
module tb_mips_decode_exec_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [31:0] out_rs, out_rt;
    logic        sinal_escrita;
    logic [4:0]  reg_escrita;
    logic [31:0] dado_escrita;
    logic [1:0]  c_ALUOp, c_memoria;
    logic [2:0]  c_desvio;
    logic        c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_funct;
    logic [1:0]  alu_op;
    logic [31:0] resultado;
    logic        zero, overflow;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_regs [32];

    always #5 clock = ~clock;

    mips_decode_exec_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .out_rs         (out_rs),
        .out_rt         (out_rt),
        .sinal_escrita  (sinal_escrita),
        .reg_escrita    (reg_escrita),
        .dado_escrita   (dado_escrita),
        .c_ALUOp        (c_ALUOp),
        .c_memoria      (c_memoria),
        .c_desvio       (c_desvio),
        .c_fonte_ula    (c_fonte_ula),
        .c_memtoreg     (c_memtoreg),
        .c_escrever_reg (c_escrever_reg),
        .c_reg_destino  (c_reg_destino),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_funct      (alu_funct),
        .alu_op         (alu_op),
        .resultado      (resultado),
        .zero           (zero),
        .overflow       (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control table, straight from the opcode list.
    function automatic logic [10:0] ctrl_model(input logic [5:0] op);
        case (op)
            6'b000000: return {2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
            6'b100011: return {2'b00, 2'b01, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0};
            6'b101011: return {2'b00, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0};
            6'b000100: return {2'b01, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
            6'b000101: return {2'b01, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
            6'b001000: return {2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0};
            6'b000010: return {2'b00, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0};
            default:   return 11'd0;
        endcase
    endfunction

    // ALU model with 64-bit signed arithmetic; returns {overflow, zero, result}.
    function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op, input logic [5:0] fn);
        longint sa, sb, s;
        logic [31:0] r;
        logic ov;
        string kind;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        kind = "add";
        if (op == 2'b01) kind = "sub";
        else if (op == 2'b10) begin
            case (fn)
                6'b100010: kind = "sub";
                6'b100100: kind = "and";
                6'b100101: kind = "or";
                6'b100111: kind = "nor";
                6'b101010: kind = "slt";
                default:   kind = "add";
            endcase
        end
        ov = 1'b0;
        if (kind == "add" || kind == "sub") begin
            s = (kind == "add") ? sa + sb : sa - sb;
            r = s[31:0];
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (kind == "and") r = a & b;
        else if (kind == "or") r = a | b;
        else if (kind == "nor") r = ~(a | b);
        else r = (sa < sb) ? 32'd1 : 32'd0;
        return {ov, (r == 32'd0), r};
    endfunction

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clock);
        sinal_escrita = 1'b1;
        reg_escrita   = idx;
        dado_escrita  = data;
        @(posedge clock);
        #1;
        sinal_escrita = 1'b0;
        if (reset_n && idx != 5'd0) model_regs[idx] = data;
    endtask

    task automatic check_alu(input string tag);
        logic [33:0] e;
        #1;
        e = alu_model(alu_a, alu_b, alu_op, alu_funct);
        check({tag, ".res"}, resultado, e[31:0]);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, e[32]});
        check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e[33]});
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] fns [7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000011};
        for (int i = 0; i < 32; i++) model_regs[i] = '0;

        reset_n = 1'b0;
        opcode = '0; rs = 5'd5; rt = 5'd6;
        sinal_escrita = 1'b0; reg_escrita = '0; dado_escrita = '0;
        alu_a = '0; alu_b = '0; alu_funct = '0; alu_op = '0;
        #1;
        check("reset.out_rs", out_rs, 32'd0);
        check("reset.out_rt", out_rt, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic writes and reads
        write_reg(5'd5, 32'h0000_1234);
        write_reg(5'd6, 32'hFFFF_FFFF);
        rs = 5'd5; rt = 5'd6; #1;
        check("rf.r5", out_rs, 32'h0000_1234);
        check("rf.r6", out_rt, 32'hFFFF_FFFF);

        write_reg(5'd0, 32'hDEAD_BEEF);
        rs = 5'd0; #1;
        check("rf.r0", out_rs, 32'd0);

        // Write-through on both ports before the edge
        @(negedge clock);
        rs = 5'd7; rt = 5'd7;
        sinal_escrita = 1'b1; reg_escrita = 5'd7; dado_escrita = 32'hA5A5_A5A5;
        #1;
        check("bypass.rs", out_rs, 32'hA5A5_A5A5);
        check("bypass.rt", out_rt, 32'hA5A5_A5A5);
        @(posedge clock); #1;
        sinal_escrita = 1'b0; model_regs[7] = 32'hA5A5_A5A5;
        rt = 5'd6; #1;
        check("bypass.held", out_rs, 32'hA5A5_A5A5);
        check("bypass.rt_other", out_rt, 32'hFFFF_FFFF);

        // Control decoder: listed opcodes, then random ones
        foreach (ops[i]) begin
            opcode = ops[i]; #1;
            check($sformatf("ctrl.%b", ops[i]),
                  {21'd0, c_ALUOp, c_memoria, c_desvio, c_fonte_ula, c_memtoreg,
                   c_escrever_reg, c_reg_destino}, {21'd0, ctrl_model(ops[i])});
        end
        for (int i = 0; i < 20; i++) begin
            opcode = 6'($urandom_range(0, 63)); #1;
            check("ctrl.rand",
                  {21'd0, c_ALUOp, c_memoria, c_desvio, c_fonte_ula, c_memtoreg,
                   c_escrever_reg, c_reg_destino}, {21'd0, ctrl_model(opcode)});
        end

        // Directed ALU corner cases
        alu_op = 2'b10; alu_funct = 6'b100000; alu_a = 32'h7FFF_FFFF; alu_b = 32'd1;
        check_alu("alu.add_ovf");
        #1 check("alu.add_ovf.exact", {30'd0, overflow, zero}, {30'd0, 1'b1, 1'b0});
        alu_op = 2'b01; alu_a = 32'd5; alu_b = 32'd5;
        check_alu("alu.sub_zero");
        check("alu.sub_zero.exact", resultado, 32'd0);
        alu_op = 2'b10; alu_funct = 6'b101010; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1;
        check_alu("alu.slt_neg");
        check("alu.slt_neg.exact", resultado, 32'd1);
        alu_funct = 6'b101010; alu_a = 32'h8000_0000; alu_b = 32'h7FFF_FFFF;
        check_alu("alu.slt_wrap");
        alu_funct = 6'b100111; alu_a = 32'd0; alu_b = 32'd0;
        check_alu("alu.nor");
        check("alu.nor.exact", resultado, 32'hFFFF_FFFF);
        alu_funct = 6'b100010; alu_a = 32'h8000_0000; alu_b = 32'd1;
        check_alu("alu.sub_ovf");

        // Random ALU traffic
        for (int i = 0; i < 60; i++) begin
            alu_op = 2'($urandom_range(0, 3));
            alu_funct = (i % 3 == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 6)];
            alu_a = (i % 4 == 0) ? {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'h7FFF_FFFF} : $urandom;
            alu_b = (i % 5 == 0) ? alu_a : $urandom;
            check_alu("alu.rand");
        end

        // Random register-file traffic with reads during pending writes
        for (int i = 0; i < 60; i++) begin
            logic [4:0] wi;
            logic [31:0] wd;
            wi = 5'($urandom_range(0, 31));
            wd = $urandom;
            @(negedge clock);
            rs = 5'($urandom_range(0, 31));
            rt = (i % 4 == 0) ? wi : 5'($urandom_range(0, 31));
            sinal_escrita = 1'($urandom_range(0, 1));
            reg_escrita = wi; dado_escrita = wd;
            #1;
            check("rf.rand.rs", out_rs, (sinal_escrita && wi != 0 && rs == wi) ? wd
                                        : (rs == 0 ? 32'd0 : model_regs[rs]));
            check("rf.rand.rt", out_rt, (sinal_escrita && wi != 0 && rt == wi) ? wd
                                        : (rt == 0 ? 32'd0 : model_regs[rt]));
            @(posedge clock); #1;
            if (sinal_escrita && wi != 0) model_regs[wi] = wd;
            sinal_escrita = 1'b0;
        end

        // Mid-cycle asynchronous reset
        write_reg(5'd9, 32'h1357_9BDF);
        rs = 5'd9; rt = 5'd5; #1;
        check("prereset.r9", out_rs, 32'h1357_9BDF);
        @(posedge clock); #2;
        reset_n = 1'b0; #1;
        check("async_reset.rs", out_rs, 32'd0);
        check("async_reset.rt", out_rt, 32'd0);
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        // Writes while held in reset are dropped
        @(negedge clock);
        sinal_escrita = 1'b1; reg_escrita = 5'd9; dado_escrita = 32'hFFFF_0000;
        @(posedge clock); #1;
        sinal_escrita = 1'b0;
        @(negedge clock);
        reset_n = 1'b1; #1;
        check("post_reset.r9", out_rs, 32'd0);
        check("post_reset.r5", out_rt, 32'd0);
        write_reg(5'd9, 32'h0BAD_F00D);
        check("post_reset.first_write", out_rs, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
